// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: steps the shared datapath through fetch,
// decode, execute, memory and write-back, and stalls on mem_ready.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instr at PC, PC+4 into PC, load IR on mem_ready
// DECODE | read regs into A/B, branch target into ALUOut
// MEMADR | effective address A + imm into ALUOut
// MEMRD  | load data read at ALUOut, waits on mem_ready
// MEMWB  | MDR written to rt
// MEMWR  | store B at ALUOut, waits on mem_ready
// REXEC  | A funct B
// RWB    | ALUOut written to rd
// BRANCH | A - B, PC <= ALUOut when zero
// JUMP   | PC <= jump target
// IEXEC  | A + imm
// IWB    | ALUOut written to rt
// TRAP   | unsupported opcode, parked until reset
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             illegal_q, illegal_d;

  // State, retired counter and sticky illegal flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
      illegal_q     <= illegal_d;
    end
  end

  // Next-state decode; opcode is only looked at while the IR is stable
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_REXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath controls per state; reset forces every enable and select low
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // PC and IR load only on the ready cycle so a stall cannot
        // advance the PC twice
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
    end
  end

  // Retire counter wraps naturally; illegal sets on entry to TRAP
  always_comb begin
    instr_count_d = instr_count_q + CNT_W'(instr_done);
    illegal_d     = illegal_q | (state_d == S_TRAP);
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vectors of inputs and
// hand-derived expected state, control word and retired count.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clock;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic             instr_done, illegal;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal(illegal), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] ILL = 6'b111111;

  typedef struct {
    logic             rst;
    logic [5:0]       op;
    logic             rdy;
    logic [3:0]       st;
    logic [17:0]      ctrl;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Control word layout:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
  //  pc_source, instr_done, illegal}
  function automatic logic [17:0] mk(
    input logic pcw, input logic pcwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic m2r, input logic rdst,
    input logic rw, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] psrc, input logic done,
    input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  logic [17:0] c_zero, c_fetch_r, c_fetch_w, c_decode, c_memadr, c_memrd;
  logic [17:0] c_memwb, c_memwr_r, c_memwr_w, c_rexec, c_rwb, c_branch;
  logic [17:0] c_jump, c_iexec, c_iwb, c_trap;

  function automatic logic [17:0] act_ctrl();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, instr_done, illegal};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [17:0] ctrl,
                     input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs just after the edge, compare at the falling edge
  task automatic apply(input string name, input int idx, input logic rst,
                       input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [17:0] ctrl,
                       input logic [CNT_W-1:0] cnt);
    reset = rst; opcode = op; mem_ready = rdy;
    @(negedge clock);
    n_checks++;
    if (state === st) n_pass++;
    else $display("FAIL %s[%0d] state: got %0d want %0d", name, idx, state, st);
    n_checks++;
    if (act_ctrl() === ctrl) n_pass++;
    else $display("FAIL %s[%0d] ctrl: got %b want %b", name, idx, act_ctrl(), ctrl);
    n_checks++;
    if (instr_count === cnt) n_pass++;
    else $display("FAIL %s[%0d] instr_count: got %0d want %0d", name, idx, instr_count, cnt);
    @(posedge clock);
    #1;
  endtask

  initial begin
    //              pcw pcwc iord mr mw irw m2r rdst rw asa asb    aop    psrc  done ill
    c_zero    = mk(0,  0,   0,   0, 0, 0,  0,  0,   0, 0,  2'b00, 2'b00, 2'b00, 0, 0);
    c_fetch_r = mk(1,  0,   0,   1, 0, 1,  0,  0,   0, 0,  2'b01, 2'b00, 2'b00, 0, 0);
    c_fetch_w = mk(0,  0,   0,   1, 0, 0,  0,  0,   0, 0,  2'b01, 2'b00, 2'b00, 0, 0);
    c_decode  = mk(0,  0,   0,   0, 0, 0,  0,  0,   0, 0,  2'b11, 2'b00, 2'b00, 0, 0);
    c_memadr  = mk(0,  0,   0,   0, 0, 0,  0,  0,   0, 1,  2'b10, 2'b00, 2'b00, 0, 0);
    c_memrd   = mk(0,  0,   1,   1, 0, 0,  0,  0,   0, 0,  2'b00, 2'b00, 2'b00, 0, 0);
    c_memwb   = mk(0,  0,   0,   0, 0, 0,  1,  0,   1, 0,  2'b00, 2'b00, 2'b00, 1, 0);
    c_memwr_r = mk(0,  0,   1,   0, 1, 0,  0,  0,   0, 0,  2'b00, 2'b00, 2'b00, 1, 0);
    c_memwr_w = mk(0,  0,   1,   0, 1, 0,  0,  0,   0, 0,  2'b00, 2'b00, 2'b00, 0, 0);
    c_rexec   = mk(0,  0,   0,   0, 0, 0,  0,  0,   0, 1,  2'b00, 2'b10, 2'b00, 0, 0);
    c_rwb     = mk(0,  0,   0,   0, 0, 0,  0,  1,   1, 0,  2'b00, 2'b00, 2'b00, 1, 0);
    c_branch  = mk(0,  1,   0,   0, 0, 0,  0,  0,   0, 1,  2'b00, 2'b01, 2'b01, 1, 0);
    c_jump    = mk(1,  0,   0,   0, 0, 0,  0,  0,   0, 0,  2'b00, 2'b00, 2'b10, 1, 0);
    c_iexec   = mk(0,  0,   0,   0, 0, 0,  0,  0,   0, 1,  2'b10, 2'b00, 2'b00, 0, 0);
    c_iwb     = mk(0,  0,   0,   0, 0, 0,  0,  0,   1, 0,  2'b00, 2'b00, 2'b00, 1, 0);
    c_trap    = mk(0,  0,   0,   0, 0, 0,  0,  0,   0, 0,  2'b00, 2'b00, 2'b00, 0, 1);

    // lw, ready throughout: 5 cycles
    add(0, LW, 1, 0, c_fetch_r, 0);  add(0, LW, 1, 1, c_decode, 0);
    add(0, LW, 1, 2, c_memadr, 0);   add(0, LW, 1, 3, c_memrd, 0);
    add(0, LW, 1, 4, c_memwb, 0);
    // R-type: 4 cycles
    add(0, R_OP, 1, 0, c_fetch_r, 1); add(0, R_OP, 1, 1, c_decode, 1);
    add(0, R_OP, 1, 6, c_rexec, 1);   add(0, R_OP, 1, 7, c_rwb, 1);
    // addi: 4 cycles
    add(0, ADDI, 1, 0, c_fetch_r, 2); add(0, ADDI, 1, 1, c_decode, 2);
    add(0, ADDI, 1, 10, c_iexec, 2);  add(0, ADDI, 1, 11, c_iwb, 2);
    // sw: 4 cycles
    add(0, SW, 1, 0, c_fetch_r, 3);  add(0, SW, 1, 1, c_decode, 3);
    add(0, SW, 1, 2, c_memadr, 3);   add(0, SW, 1, 5, c_memwr_r, 3);
    // beq, j: 3 cycles each
    add(0, BEQ, 1, 0, c_fetch_r, 4); add(0, BEQ, 1, 1, c_decode, 4);
    add(0, BEQ, 1, 8, c_branch, 4);
    add(0, JMP, 1, 0, c_fetch_r, 5); add(0, JMP, 1, 1, c_decode, 5);
    add(0, JMP, 1, 9, c_jump, 5);
    // fetch stalled 3 cycles; mem_ready low elsewhere is ignored
    add(0, R_OP, 0, 0, c_fetch_w, 6); add(0, R_OP, 0, 0, c_fetch_w, 6);
    add(0, R_OP, 0, 0, c_fetch_w, 6); add(0, R_OP, 1, 0, c_fetch_r, 6);
    add(0, R_OP, 0, 1, c_decode, 6);  add(0, R_OP, 0, 6, c_rexec, 6);
    add(0, R_OP, 0, 7, c_rwb, 6);
    // sw with 2 stall cycles in MEMWR
    add(0, SW, 1, 0, c_fetch_r, 7);  add(0, SW, 1, 1, c_decode, 7);
    add(0, SW, 0, 2, c_memadr, 7);   add(0, SW, 0, 5, c_memwr_w, 7);
    add(0, SW, 0, 5, c_memwr_w, 7);  add(0, SW, 1, 5, c_memwr_r, 7);
    // lw with 1 stall cycle in MEMRD
    add(0, LW, 1, 0, c_fetch_r, 8);  add(0, LW, 1, 1, c_decode, 8);
    add(0, LW, 1, 2, c_memadr, 8);   add(0, LW, 0, 3, c_memrd, 8);
    add(0, LW, 1, 3, c_memrd, 8);    add(0, LW, 1, 4, c_memwb, 8);

    reset = 1'b1; opcode = 6'b0; mem_ready = 1'b1;
    @(posedge clock);
    #1;
    apply("reset", 0, 1, LW, 1, 0, c_zero, 0);

    foreach (vecs[i])
      apply("vec", i, vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].st,
            vecs[i].ctrl, vecs[i].cnt);

    // Illegal opcode parks in TRAP with no enables
    apply("ill_fetch", 0, 0, ILL, 1, 0, c_fetch_r, 9);
    apply("ill_decode", 0, 0, ILL, 1, 1, c_decode, 9);
    for (int i = 0; i < 10; i++) apply("trap", i, 0, ILL, 1, 12, c_trap, 9);
    // Reset out of TRAP: enables low now, illegal clears at the edge
    apply("trap_reset", 0, 1, ILL, 1, 12, c_trap, 9);

    // lw aborted by reset in MEMRD
    apply("abort", 0, 0, LW, 1, 0, c_fetch_r, 0);
    apply("abort", 1, 0, LW, 1, 1, c_decode, 0);
    apply("abort", 2, 0, LW, 1, 2, c_memadr, 0);
    apply("abort", 3, 1, LW, 1, 3, c_zero, 0);

    // 16 jumps wrap a 4-bit retired counter back to 0
    for (int k = 0; k < 16; k++) begin
      apply("wrap_f", k, 0, JMP, 1, 0, c_fetch_r, CNT_W'(k));
      apply("wrap_d", k, 0, JMP, 1, 1, c_decode, CNT_W'(k));
      apply("wrap_j", k, 0, JMP, 1, 9, c_jump, CNT_W'(k));
    end
    apply("wrap_end", 0, 0, JMP, 1, 0, c_fetch_r, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
